// File: rtl/loader_pkg.sv
// Shared constants and types for the byte-serial image loader.
// The optional checksum feature is selected in image_loader by LOADER_CHECKSUM_EN.
package loader_pkg;

    localparam int NUM_BYTES = 16;
    localparam int BYTE_W    = 8;
    localparam int IDX_W     = $clog2(NUM_BYTES + 1);
    localparam int DATA_W    = NUM_BYTES * BYTE_W;

    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } state_t;

    typedef logic             bank_idx_t;
    typedef logic [IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/loader_bank.sv
// One image bank: a NUM_BYTES*BYTE_W register written one byte at a time.
// Indices at or beyond NUM_BYTES (the checksum slot) write nothing.
module loader_bank
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  byte_idx_t         idx,
    input  logic [BYTE_W-1:0] wdata,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (we && (idx == byte_idx_t'(k))) begin
                data_d[k*BYTE_W +: BYTE_W] = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/image_loader.sv
// Byte-serial image loader with two ping-pong banks feeding the multiplier array.
// Define LOADER_CHECKSUM_EN to expect a trailing mod-256 checksum byte per frame.
module image_loader
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              frame_err,
    output logic [7:0]        frame_count
);

`ifdef LOADER_CHECKSUM_EN
    localparam int FRAME_LEN = NUM_BYTES + 1;
`else
    localparam int FRAME_LEN = NUM_BYTES;
`endif
    localparam byte_idx_t LAST_IDX   = byte_idx_t'(FRAME_LEN - 1);
    localparam byte_idx_t DATA_LIMIT = byte_idx_t'(NUM_BYTES);

    state_t      state_q, state_d;
    byte_idx_t   idx_q, idx_d;
    bank_idx_t   wr_bank_q, wr_bank_d;
    bank_idx_t   rd_bank_q, rd_bank_d;
    logic [1:0]  full_q, full_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  frame_count_q, frame_count_d;

    logic        accept;
    logic        at_last;
    logic        chk_ok;
    logic [1:0]  bank_we;
    logic [DATA_W-1:0] bank_data [2];

    // in_ready depends only on registered state, never on in_valid.
    assign in_ready = (state_q == DROP) || !full_q[wr_bank_q];
    assign accept   = in_valid && in_ready;
    assign at_last  = (idx_q == LAST_IDX);

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (accept && (state_q == FILL)) begin
            if (in_last || at_last) begin
                sum_d = '0;
            end else if (idx_q < DATA_LIMIT) begin
                sum_d = sum_q + in_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign chk_ok = (in_byte == sum_q);
`else
    assign chk_ok = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        full_d        = full_q;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        bank_we       = 2'b00;

        if (accept) begin
            if (state_q == FILL) begin
                bank_we[wr_bank_q] = (idx_q < DATA_LIMIT);
                if (in_last) begin
                    idx_d = '0;
                    if (at_last && chk_ok) begin
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = ~wr_bank_q;
                        frame_count_d     = frame_count_q + 8'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (at_last) begin
                    // Over-long frame: report once, then swallow up to in_last.
                    frame_err_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DROP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else if (in_last) begin
                state_d = FILL;
                idx_d   = '0;
            end
        end

        // The bank being completed is never the one being acked, so both apply.
        if (out_ack && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FILL;
            idx_q         <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            full_q        <= 2'b00;
            frame_err_q   <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            full_q        <= full_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    loader_bank u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we[0]),
        .idx   (idx_q),
        .wdata (in_byte),
        .data  (bank_data[0])
    );

    loader_bank u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we[1]),
        .idx   (idx_q),
        .wdata (in_byte),
        .data  (bank_data[1])
    );

    // Gate the mux so a partially written bank never shows on out_data.
    assign out_valid   = full_q[rd_bank_q];
    assign out_data    = out_valid ? bank_data[rd_bank_q] : '0;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

endmodule
